// File: rtl/f_accum_pool_if.sv
// Pooling accumulator bus: configuration/sample inputs and per-window result outputs.
// No backpressure: results are single-cycle pulses, the producer is throttled only by running.
interface f_accum_pool_if #(
  parameter int DATA_W   = 32,
  parameter int DELAY_W  = 7,
  parameter int CHANNELS = 4
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic               run;
  logic               running;
  logic [DELAY_W-1:0] delay0;
  logic [DELAY_W-1:0] strideMinusOne;
  logic               mode;
  logic [DATA_W-1:0]  in0;
  logic [DATA_W-1:0]  out0;
  logic [DELAY_W-1:0] outIdx;
  logic [CH_W-1:0]    outCh;
  logic               outValid;

  modport master (
    output run, running, delay0, strideMinusOne, mode, in0,
    input  out0, outIdx, outCh, outValid
  );

  modport slave (
    input  run, running, delay0, strideMinusOne, mode, in0,
    output out0, outIdx, outCh, outValid
  );
endinterface

// File: rtl/f_accum_pool.sv
// Interleaved per-channel float max/min pooling with argmax index; result 1 cycle after each sample.
// No backpressure: running stalls everything, outValid pulses when a channel's window completes.
module f_accum_pool #(
  parameter int DATA_W   = 32,
  parameter int DELAY_W  = 7,
  parameter int CHANNELS = 4
) (
  input logic           clk,
  input logic           rst,
  f_accum_pool_if.slave bus
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NCH  = 1 << CH_W;

  typedef enum logic [1:0] {IDLE, DELAY, ACCUM} state_t;

  state_t             state, state_nxt;
  logic [DELAY_W-1:0] dcnt;
  logic [CH_W-1:0]    ch;
  logic [DELAY_W-1:0] pos;
  logic               mode_q;
  logic [DATA_W-1:0]  best [NCH];
  logic [DELAY_W-1:0] idx  [NCH];
  logic               accept, dec;
  logic [DATA_W-1:0]  new_best;
  logic [DELAY_W-1:0] new_idx;

  // Strict "a above b" in max ordering on raw sign-magnitude bits (+0 above -0, NaN unspecial).
  function automatic logic max_gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W-2:0] ma, mb;
    ma = a[DATA_W-2:0];
    mb = b[DATA_W-2:0];
    if (a[DATA_W-1] != b[DATA_W-1])
      return !a[DATA_W-1];
    else if (!a[DATA_W-1])
      return ma > mb;
    else
      return ma < mb;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    dec       = 1'b0;
    case (state)
      IDLE:  ;
      DELAY: if (bus.running) begin
        dec = 1'b1;
        if (dcnt == DELAY_W'(1)) state_nxt = ACCUM;
      end
      ACCUM: accept = bus.running;
      default: state_nxt = IDLE;
    endcase
    // A run pulse wins over a concurrent sample, which is dropped.
    if (bus.run) begin
      accept    = 1'b0;
      dec       = 1'b0;
      state_nxt = (bus.delay0 != '0) ? DELAY : ACCUM;
    end
  end

  always_comb begin
    new_best = best[ch];
    new_idx  = idx[ch];
    if (pos == '0) begin
      new_best = bus.in0;
      new_idx  = '0;
    end else if (mode_q ? max_gt(best[ch], bus.in0) : max_gt(bus.in0, best[ch])) begin
      new_best = bus.in0;
      new_idx  = pos;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt         <= '0;
      ch           <= '0;
      pos          <= '0;
      mode_q       <= 1'b0;
      bus.out0     <= '0;
      bus.outIdx   <= '0;
      bus.outCh    <= '0;
      bus.outValid <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        best[i] <= '0;
        idx[i]  <= '0;
      end
    end else if (bus.run) begin
      dcnt         <= bus.delay0;
      ch           <= '0;
      pos          <= '0;
      mode_q       <= bus.mode;
      bus.outValid <= 1'b0;
    end else begin
      bus.outValid <= 1'b0;
      if (dec) dcnt <= dcnt - DELAY_W'(1);
      if (accept) begin
        best[ch]     <= new_best;
        idx[ch]      <= new_idx;
        bus.out0     <= new_best;
        bus.outIdx   <= new_idx;
        bus.outCh    <= ch;
        bus.outValid <= (pos == bus.strideMinusOne);
        if (ch == CH_W'(CHANNELS - 1)) begin
          ch  <= '0;
          pos <= (pos == bus.strideMinusOne) ? '0 : pos + DELAY_W'(1);
        end else begin
          ch <= ch + CH_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_f_accum_pool.sv
// Directed vector bench for f_accum_pool: single-channel table plus two-channel and reset sequences.
module tb_f_accum_pool;
  localparam logic [31:0] P0 = 32'h0000_0000, N0 = 32'h8000_0000;
  localparam logic [31:0] P1 = 32'h3F80_0000, N1 = 32'hBF80_0000;
  localparam logic [31:0] P2 = 32'h4000_0000, N2 = 32'hC000_0000;
  localparam logic [31:0] P35 = 32'h4060_0000, P4 = 32'h4080_0000;
  localparam logic [31:0] N5 = 32'hC0A0_0000, P7 = 32'h40E0_0000, P9 = 32'h4110_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  f_accum_pool_if #(.DATA_W(32), .DELAY_W(7), .CHANNELS(1)) b1();
  f_accum_pool_if #(.DATA_W(32), .DELAY_W(7), .CHANNELS(2)) b2();

  f_accum_pool #(.DATA_W(32), .DELAY_W(7), .CHANNELS(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  f_accum_pool #(.DATA_W(32), .DELAY_W(7), .CHANNELS(2)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  typedef struct {
    logic        run;
    logic        running;
    logic        mode;
    logic [6:0]  delay0;
    logic [6:0]  smo;
    logic [31:0] in0;
    logic        exp_v;
    logic [31:0] exp_out;
    logic [6:0]  exp_idx;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic rn, input logic m, input logic [6:0] d,
                              input logic [6:0] s, input logic [31:0] x, input logic v,
                              input logic [31:0] o, input logic [6:0] ix);
    vec_t t;
    t.run = r; t.running = rn; t.mode = m; t.delay0 = d; t.smo = s; t.in0 = x;
    t.exp_v = v; t.exp_out = o; t.exp_idx = ix;
    return t;
  endfunction

  initial begin
    b1.run = 0; b1.running = 1; b1.mode = 0; b1.delay0 = 0; b1.strideMinusOne = 0; b1.in0 = P1;
    b2.run = 0; b2.running = 0; b2.mode = 0; b2.delay0 = 0; b2.strideMinusOne = 0; b2.in0 = P0;

    // max, window 4, tie keeps earliest
    tbl.push_back(mk(1, 0, 0, 0, 3, P0,  0, P0,  0));
    tbl.push_back(mk(0, 1, 0, 0, 3, P1,  0, P1,  0));
    tbl.push_back(mk(0, 1, 0, 0, 3, N2,  0, P1,  0));
    tbl.push_back(mk(0, 1, 0, 0, 3, P35, 0, P35, 2));
    tbl.push_back(mk(0, 1, 0, 0, 3, P35, 1, P35, 2));
    tbl.push_back(mk(0, 0, 0, 0, 3, P1,  0, P35, 2));
    // min mode
    tbl.push_back(mk(1, 0, 1, 0, 3, P0,  0, P35, 2));
    tbl.push_back(mk(0, 1, 1, 0, 3, N1,  0, N1,  0));
    tbl.push_back(mk(0, 1, 1, 0, 3, N5,  0, N5,  1));
    tbl.push_back(mk(0, 1, 1, 0, 3, P0,  0, N5,  1));
    tbl.push_back(mk(0, 1, 1, 0, 3, N5,  1, N5,  1));
    // signed zeros, both modes
    tbl.push_back(mk(1, 0, 0, 0, 1, P0,  0, N5,  1));
    tbl.push_back(mk(0, 1, 0, 0, 1, N0,  0, N0,  0));
    tbl.push_back(mk(0, 1, 0, 0, 1, P0,  1, P0,  1));
    tbl.push_back(mk(1, 0, 1, 0, 1, P0,  0, P0,  1));
    tbl.push_back(mk(0, 1, 1, 0, 1, P0,  0, P0,  0));
    tbl.push_back(mk(0, 1, 1, 0, 1, N0,  1, N0,  1));
    // delay0 = 3, stall mid-window
    tbl.push_back(mk(1, 0, 0, 3, 2, P0,  0, N0,  1));
    tbl.push_back(mk(0, 1, 0, 3, 2, P7,  0, N0,  1));
    tbl.push_back(mk(0, 1, 0, 3, 2, P7,  0, N0,  1));
    tbl.push_back(mk(0, 1, 0, 3, 2, P7,  0, N0,  1));
    tbl.push_back(mk(0, 1, 0, 3, 2, P1,  0, P1,  0));
    tbl.push_back(mk(0, 0, 0, 3, 2, P9,  0, P1,  0));
    tbl.push_back(mk(0, 0, 0, 3, 2, P9,  0, P1,  0));
    tbl.push_back(mk(0, 1, 0, 3, 2, P2,  0, P2,  1));
    tbl.push_back(mk(0, 1, 0, 3, 2, N1,  1, P2,  1));
    // window of one: pass-through
    tbl.push_back(mk(1, 0, 0, 0, 0, P0,  0, P2,  1));
    tbl.push_back(mk(0, 1, 0, 0, 0, N2,  1, N2,  0));
    tbl.push_back(mk(0, 1, 0, 0, 0, P1,  1, P1,  0));
    tbl.push_back(mk(0, 1, 0, 0, 0, N5,  1, N5,  0));
    // run mid-window abandons the partial window and drops its own sample
    tbl.push_back(mk(1, 0, 0, 0, 3, P0,  0, N5,  0));
    tbl.push_back(mk(0, 1, 0, 0, 3, P4,  0, P4,  0));
    tbl.push_back(mk(0, 1, 0, 0, 3, P2,  0, P4,  0));
    tbl.push_back(mk(1, 1, 0, 0, 3, P9,  0, P4,  0));
    tbl.push_back(mk(0, 1, 0, 0, 3, P1,  0, P1,  0));
    tbl.push_back(mk(0, 1, 0, 0, 3, N1,  0, P1,  0));
    tbl.push_back(mk(0, 1, 0, 0, 3, N2,  0, P1,  0));
    tbl.push_back(mk(0, 1, 0, 0, 3, P35, 1, P35, 3));

    // reset state, with running high
    repeat (2) tick();
    chk("rst_out1", {b1.outValid, b1.out0, b1.outIdx, 1'b0, b1.outCh}, 64'd0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_no_run", {b1.outValid, b1.out0, b1.outIdx}, 64'd0);

    foreach (tbl[i]) begin
      b1.run = tbl[i].run; b1.running = tbl[i].running; b1.mode = tbl[i].mode;
      b1.delay0 = tbl[i].delay0; b1.strideMinusOne = tbl[i].smo; b1.in0 = tbl[i].in0;
      tick();
      chk($sformatf("vec%0d", i), {b1.outValid, b1.out0, b1.outIdx},
          {tbl[i].exp_v, tbl[i].exp_out, tbl[i].exp_idx});
    end
    b1.run = 0; b1.running = 0;

    // two interleaved channels, window 2
    b2.run = 1; b2.strideMinusOne = 1; tick();
    b2.run = 0; b2.running = 1;
    b2.in0 = P2; tick();
    chk("ch2_s0", {b2.outValid, b2.outCh, b2.out0, b2.outIdx}, {1'b0, 1'b0, P2, 7'd0});
    b2.in0 = N1; tick();
    chk("ch2_s1", {b2.outValid, b2.outCh, b2.out0, b2.outIdx}, {1'b0, 1'b1, N1, 7'd0});
    b2.in0 = P1; tick();
    chk("ch2_s2", {b2.outValid, b2.outCh, b2.out0, b2.outIdx}, {1'b1, 1'b0, P2, 7'd0});
    b2.in0 = P4; tick();
    chk("ch2_s3", {b2.outValid, b2.outCh, b2.out0, b2.outIdx}, {1'b1, 1'b1, P4, 7'd1});
    b2.running = 0; tick();
    chk("ch2_hold", {b2.outValid, b2.outCh, b2.out0, b2.outIdx}, {1'b0, 1'b1, P4, 7'd1});

    // asynchronous reset in the middle of a window
    b1.run = 1; b1.mode = 0; b1.delay0 = 0; b1.strideMinusOne = 3; tick();
    b1.run = 0; b1.running = 1;
    b1.in0 = P1; tick();
    b1.in0 = P35; tick();
    chk("pre_rst", {b1.outValid, b1.out0, b1.outIdx}, {1'b0, P35, 7'd1});
    #2 rst = 1'b1;
    #1;
    chk("async_rst1", {b1.outValid, b1.out0, b1.outIdx, 1'b0, b1.outCh}, 64'd0);
    chk("async_rst2", {b2.outValid, b2.out0, b2.outIdx, b2.outCh}, 64'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b1.in0 = P4;
      tick();
      chk($sformatf("post_rst_idle%0d", k), {b1.outValid, b1.out0, b1.outIdx}, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/f_accum_pool.md
F_ACCUM_POOL -- requirements
Module: f_accum_pool

Interface
REQ-001 Parameter DATA_W, default 32, sample width; IEEE-754 sign-magnitude float bit pattern.
REQ-002 Parameter DELAY_W, default 7, width of delay, window and index counters.
REQ-003 Parameter CHANNELS, default 4, interleaved channels; CH_W = max(1, clog2(CHANNELS)).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 run  input  1  one-cycle start pulse; loads configuration and restarts all counters.
REQ-007 running  input  1  cycle enable; when low, all state holds.
REQ-008 delay0  input  DELAY_W  number of running cycles to discard after run before the first sample.
REQ-009 strideMinusOne  input  DELAY_W  window length per channel minus one.
REQ-010 mode  input  1  0 = max pooling, 1 = min pooling; sampled at run.
REQ-011 in0  input  DATA_W  sample; channel order 0..CHANNELS-1 repeating, one sample per running cycle.
REQ-012 out0  output  DATA_W  running best value of the channel updated in the previous cycle (latency 1).
REQ-013 outIdx  output  DELAY_W  in-window position of out0's best sample.
REQ-014 outCh  output  CH_W  channel of out0.
REQ-015 outValid  output  1  high one cycle when out0 is a completed window result.

Function
REQ-016 On run, the block SHALL load delay counter = delay0, ch = 0, pos = 0, latch mode, and clear outValid.
REQ-017 While running and delay counter != 0, it SHALL decrement the counter, discard in0, and hold outValid low.
REQ-018 While running and delay counter == 0, in0 SHALL belong to channel ch at window position pos.
REQ-019 Per accepted sample: ch increments and wraps CHANNELS-1 -> 0; on that wrap, pos increments and wraps strideMinusOne -> 0.
REQ-020 At pos == 0, best[ch] SHALL be loaded with in0 and idx[ch] with 0, with no comparison.
REQ-021 At pos > 0, in0 SHALL replace best[ch] and pos SHALL replace idx[ch] only if in0 is strictly better.
REQ-022 Comparison for max: a positive sign beats a negative sign; with equal signs, the larger magnitude wins if positive and the smaller magnitude wins if negative.
REQ-023 +0 SHALL rank above -0; NaN SHALL receive no special handling (raw bit compare).
REQ-024 Min mode SHALL use the exact inverse of the max ordering.
REQ-025 Ties SHALL keep the stored value, so the earliest index wins.
REQ-026 One cycle after each accepted sample: out0/outIdx/outCh SHALL show that channel's post-update best, index and channel; outValid SHALL be 1 iff the sample had pos == strideMinusOne.
REQ-027 strideMinusOne == 0: every accepted sample SHALL pass through with outIdx 0 and outValid 1.
REQ-028 Outputs SHALL hold their values in cycles with no accepted sample, except that outValid SHALL drop to 0.
REQ-029 run asserted mid-window SHALL abandon partial windows; run SHALL take priority over running in the same cycle, and that sample is discarded.
REQ-030 strideMinusOne, delay0 and mode SHALL be stable from run until the last window completes; changes in that interval are undefined.

Reset
REQ-031 rst SHALL asynchronously clear all best[], idx[], counters, latched mode, out0, outIdx, outCh and outValid to 0.
REQ-032 After rst deasserts, the block SHALL stay idle, producing no outValid, until run.

Verification
REQ-033 CHANNELS=1, max, stride-1=3, delay0=0; in 1.0, -2.0, 3.5, 3.5 -> outValid on 4th output, out0=3.5, outIdx=2.
REQ-034 Min mode, 4 samples -1.0, -5.0, 0.0, -5.0 -> out0=-5.0, outIdx=1.
REQ-035 CHANNELS=2, stride-1=1; in ch0:2.0, ch1:-1.0, ch0:1.0, ch1:4.0 -> outValid twice: (ch0, 2.0, idx 0), then (ch1, 4.0, idx 1).
REQ-036 delay0=3 -> first 3 running cycles ignored; the 4th sample is loaded at pos 0; running low for 2 cycles mid-window -> result unchanged.
REQ-037 +0 vs -0 in max -> +0; run pulse mid-window -> no outValid from that window; rst mid-window -> all outputs 0 immediately.
